// File: rtl/pg_input_stage.sv
// Registered operand front end of the 16-bit Kogge-Stone adder: conditions add/sub
// operands into P/G plus effective carry-in and buffers them in a two-entry skid buffer.
module pg_input_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] g,
    output logic             cin_out,
    output logic             p15
);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_t;

    state_t state;
    state_t next_state;

    logic in_fire;
    logic out_fire;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] new_p;
    logic [WIDTH-1:0] new_g;
    logic             new_cin;

    logic [WIDTH-1:0] main_p;
    logic [WIDTH-1:0] main_g;
    logic             main_cin;
    logic [WIDTH-1:0] skid_p;
    logic [WIDTH-1:0] skid_g;
    logic             skid_cin;

    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    // Items are stored already conditioned, so the buffer only ever moves final values.
    always_comb begin
        b_eff   = sub ? ~b : b;
        new_p   = a ^ b_eff;
        new_g   = a & b_eff;
        new_cin = sub ? 1'b1 : cin;
    end

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state)
            EMPTY: begin
                if (in_fire) begin
                    load_main_in = 1'b1;
                    next_state   = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    load_skid  = 1'b1;
                    next_state = TWO;
                end else if (out_fire) begin
                    next_state = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    load_main_skid = 1'b1;
                    next_state     = ONE;
                end
            end
            default: begin
                next_state = EMPTY;
            end
        endcase
    end

    // Ready depends only on the state register, so downstream ready never reaches upstream combinationally.
    always_comb begin
        in_ready  = (state != TWO);
        out_valid = (state != EMPTY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_p   <= '0;
            main_g   <= '0;
            main_cin <= 1'b0;
            skid_p   <= '0;
            skid_g   <= '0;
            skid_cin <= 1'b0;
        end else begin
            if (load_main_in) begin
                main_p   <= new_p;
                main_g   <= new_g;
                main_cin <= new_cin;
            end else if (load_main_skid) begin
                main_p   <= skid_p;
                main_g   <= skid_g;
                main_cin <= skid_cin;
            end
            if (load_skid) begin
                skid_p   <= new_p;
                skid_g   <= new_g;
                skid_cin <= new_cin;
            end
        end
    end

    assign p       = main_p;
    assign g       = main_g;
    assign cin_out = main_cin;
    assign p15     = main_p[WIDTH-1];

endmodule
